// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 8-bit accumulator CPU: owns pc/ir and d_bus driver selection.
// Latency: 2 cycles for LD/JMP/JZ and 3 cycles for ALU ops and ST, plus one IDLE cycle when resuming from IDLE.
// Backpressure: run low parks the sequencer in IDLE at the next instruction boundary; run is ignored mid-instruction.
module cpu_ctrl #(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic       reset,
    input  logic       tclk,
    input  logic       run,
    input  logic [7:0] d_bus,
    input  logic       c,
    input  logic       z,
    output logic [7:0] ir,
    output logic [4:0] pc,
    output logic [4:0] addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ldAcc,
    output logic       useAlu,
    output logic       dbusSelect,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC_A, EXEC_B} state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_ST    = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    state_t     state;
    logic [2:0] op;
    logic       ends_in_a;
    logic       take_jump;
    logic       unused_carry;

    assign op        = ir[7:5];
    assign ends_in_a = (op == OP_LD) || (op == OP_JMP) || (op == OP_JZ);
    assign take_jump = (op == OP_JMP) || ((op == OP_JZ) && z);
    // Carry has no consumer among the current opcodes.
    assign unused_carry = c;

    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    ir    <= d_bus;
                    pc    <= pc + 5'd1;
                    state <= EXEC_A;
                end
                EXEC_A: begin
                    if (take_jump) pc <= ir[4:0];
                    if (ends_in_a) state <= run ? FETCH : IDLE;
                    else           state <= EXEC_B;
                end
                EXEC_B: begin
                    state <= run ? FETCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state and ir only, so reset clears them without waiting for a clock.
    always_comb begin
        addr       = pc;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ldAcc      = 1'b0;
        useAlu     = 1'b0;
        dbusSelect = 1'b0;
        busy       = (state != IDLE);
        case (state)
            FETCH: mem_rd = 1'b1;
            EXEC_A: begin
                addr = ir[4:0];
                case (op)
                    OP_ADD, OP_SUB, OP_NAND: begin
                        mem_rd = 1'b1;
                        useAlu = 1'b1;
                    end
                    OP_SHIFT, OP_ST: useAlu = 1'b1;
                    OP_LD: begin
                        mem_rd = 1'b1;
                        ldAcc  = 1'b1;
                    end
                    default: ;
                endcase
            end
            EXEC_B: begin
                addr = ir[4:0];
                case (op)
                    OP_ADD, OP_SUB, OP_NAND, OP_SHIFT: begin
                        dbusSelect = 1'b1;
                        ldAcc      = 1'b1;
                    end
                    OP_ST: begin
                        dbusSelect = 1'b1;
                        mem_wr     = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a memory/ALU/accumulator model closing the d_bus loop.
// Latency: per-cycle strobe/addr expectations are queued per program and popped each negedge.
// Backpressure: run is toggled at instruction boundaries and mid-instruction to exercise parking.
module tb_cpu_ctrl;

    logic       reset, tclk, run, c, z;
    logic [7:0] d_bus, ir;
    logic [4:0] pc, addr;
    logic       mem_rd, mem_wr, ldAcc, useAlu, dbusSelect, busy;

    logic [7:0] mem  [32];
    logic [7:0] prog [32];
    logic [7:0] acc, latch;
    logic       load;

    int tests = 0;
    int errs  = 0;
    logic [11:0] sbq [$];

    // Strobe patterns: {busy, mem_rd, mem_wr, ldAcc, useAlu, dbusSelect}
    localparam logic [5:0] IDL   = 6'b000000;
    localparam logic [5:0] FET   = 6'b110000;
    localparam logic [5:0] ALU_A = 6'b110010;
    localparam logic [5:0] ALU_B = 6'b100101;
    localparam logic [5:0] SH_A  = 6'b100010;
    localparam logic [5:0] LD_A  = 6'b110100;
    localparam logic [5:0] ST_A  = 6'b100010;
    localparam logic [5:0] ST_B  = 6'b101001;
    localparam logic [5:0] NOP   = 6'b100000;

    cpu_ctrl #(.RESET_PC(5'd0)) dut (
        .reset(reset), .tclk(tclk), .run(run), .d_bus(d_bus), .c(c), .z(z),
        .ir(ir), .pc(pc), .addr(addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ldAcc(ldAcc), .useAlu(useAlu), .dbusSelect(dbusSelect), .busy(busy)
    );

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    assign d_bus = mem_rd ? mem[addr] : (dbusSelect ? latch : 8'h00);

    always @(posedge tclk) begin
        if (load) begin
            mem <= prog;
        end else begin
            if (mem_wr) mem[addr] <= d_bus;
            if (ldAcc)  acc <= d_bus;
            if (useAlu) begin
                case (ir[7:5])
                    3'b000:  latch <= acc + d_bus;
                    3'b001:  latch <= acc - d_bus;
                    3'b010:  latch <= ~(acc & d_bus);
                    3'b011:  latch <= (ir[4:0] == 5'h1f) ? {1'b0, acc[7:1]} : {acc[6:0], 1'b0};
                    default: latch <= acc;
                endcase
            end
        end
    end

    always @(negedge tclk) begin
        tests++;
        assert (!(mem_rd && dbusSelect)) else begin
            errs++;
            $error("FAIL bus_conflict observed mem_rd=%0b dbusSelect=%0b required not both 1", mem_rd, dbusSelect);
        end
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb(input logic [5:0] s, input logic [4:0] a);
        sbq.push_back({1'b1, s, a});
    endtask

    task automatic sbx(input logic [5:0] s, input logic [4:0] a);
        sbq.push_back({1'b0, s, a});
    endtask

    task automatic cyc(input string tag);
        logic [11:0] e;
        logic [10:0] o, m;
        @(negedge tclk);
        if (sbq.size() == 0) begin
            tests++;
            errs++;
            $error("FAIL %s observed=empty scoreboard expected=queued cycle", tag);
        end else begin
            e = sbq.pop_front();
            o = {busy, mem_rd, mem_wr, ldAcc, useAlu, dbusSelect, addr};
            m = e[11] ? 11'h7ff : 11'h7e0;
            chk(tag, {1'b0, o & m}, {1'b0, e[10:0] & m});
        end
    endtask

    task automatic drain(input int n, input string tag);
        repeat (n) cyc(tag);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        run   = 1'b0;
        load  = 1'b1;
        @(posedge tclk);
        #1 load = 1'b0;
        @(negedge tclk);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; c = 1'b0; z = 1'b0; load = 1'b0;

        // LD 5, ADD 6, ST 7
        clear_prog();
        prog[0] = 8'h85; prog[1] = 8'h06; prog[2] = 8'hA7; prog[5] = 8'h10; prog[6] = 8'h22;
        hold_reset();
        chk("rst_pc", 12'(pc), 12'h000);
        chk("rst_ir", 12'(ir), 12'h000);
        chk("rst_out", 12'({busy, mem_rd, mem_wr, ldAcc, useAlu, dbusSelect}), 12'h000);
        reset = 1'b0;
        sb(IDL, 0); sb(FET, 0); sb(LD_A, 5); sb(FET, 1); sb(ALU_A, 6); sb(ALU_B, 6);
        sb(FET, 2); sb(ST_A, 7); sb(ST_B, 7); sb(IDL, 3);
        cyc("prog"); run = 1'b1;
        drain(7, "prog"); run = 1'b0;
        drain(2, "prog");
        chk("prog_mem7", 12'(mem[7]), 12'h032);
        chk("prog_acc", 12'(acc), 12'h032);
        chk("prog_pc", 12'(pc), 12'h003);

        // Reset during ST EXEC_B
        clear_prog();
        prog[0] = 8'h85; prog[1] = 8'hA7; prog[5] = 8'h11; prog[7] = 8'h5A;
        hold_reset();
        reset = 1'b0;
        sb(IDL, 0); sb(FET, 0); sb(LD_A, 5); sb(FET, 1); sb(ST_A, 7); sb(ST_B, 7);
        cyc("st_abort"); run = 1'b1;
        drain(5, "st_abort");
        #1 reset = 1'b1;
        #1;
        chk("st_abort_out", 12'({busy, mem_rd, mem_wr, ldAcc, useAlu, dbusSelect}), 12'h000);
        chk("st_abort_pc", 12'(pc), 12'h000);
        chk("st_abort_ir", 12'(ir), 12'h000);
        @(negedge tclk);
        chk("st_abort_mem7", 12'(mem[7]), 12'h05A);

        // SHIFT right
        clear_prog();
        prog[0] = 8'h85; prog[1] = 8'h7F; prog[5] = 8'h10;
        hold_reset();
        reset = 1'b0;
        sb(IDL, 0); sb(FET, 0); sb(LD_A, 5); sb(FET, 1); sbx(SH_A, 0); sbx(ALU_B, 0); sb(IDL, 2);
        cyc("shift"); run = 1'b1;
        drain(3, "shift"); run = 1'b0;
        drain(3, "shift");
        chk("shift_acc", 12'(acc), 12'h008);
        chk("shift_ir", 12'(ir), 12'h07F);

        // JMP 1F, LD at pc 31 wraps to 0
        clear_prog();
        prog[0] = 8'hDF; prog[31] = 8'h85; prog[5] = 8'h3C;
        hold_reset();
        reset = 1'b0;
        sb(IDL, 0); sb(FET, 0); sb(NOP, 5'h1f); sb(FET, 5'h1f); sb(LD_A, 5); sb(FET, 0);
        sb(NOP, 5'h1f); sb(IDL, 5'h1f);
        cyc("jmp_wrap"); run = 1'b1;
        drain(5, "jmp_wrap"); run = 1'b0;
        drain(2, "jmp_wrap");
        chk("jmp_wrap_acc", 12'(acc), 12'h03C);
        chk("jmp_wrap_pc", 12'(pc), 12'h01F);

        // JZ 1E taken
        clear_prog();
        prog[0] = 8'hFE; prog[30] = 8'h85; prog[5] = 8'h44;
        z = 1'b1;
        hold_reset();
        reset = 1'b0;
        sb(IDL, 0); sb(FET, 0); sb(NOP, 5'h1e); sb(FET, 5'h1e); sb(LD_A, 5); sb(IDL, 5'h1f);
        cyc("jz_taken"); run = 1'b1;
        drain(3, "jz_taken");
        chk("jz_taken_pc", 12'(pc), 12'h01E);
        run = 1'b0;
        drain(2, "jz_taken");
        chk("jz_taken_acc", 12'(acc), 12'h044);

        // JZ 1E not taken
        z = 1'b0;
        hold_reset();
        reset = 1'b0;
        sb(IDL, 0); sb(FET, 0); sb(NOP, 5'h1e); sb(FET, 1); sb(ALU_A, 0); sb(ALU_B, 0); sb(IDL, 2);
        cyc("jz_fall"); run = 1'b1;
        drain(3, "jz_fall");
        chk("jz_fall_pc", 12'(pc), 12'h001);
        run = 1'b0;
        drain(3, "jz_fall");

        // run dropped during ADD EXEC_A, then resumed
        clear_prog();
        prog[0] = 8'h85; prog[1] = 8'h06; prog[2] = 8'h85; prog[5] = 8'h10; prog[6] = 8'h22;
        hold_reset();
        reset = 1'b0;
        sb(IDL, 0); sb(FET, 0); sb(LD_A, 5); sb(FET, 1); sb(ALU_A, 6);
        sb(ALU_B, 6); sb(IDL, 2); sb(IDL, 2); sb(FET, 2); sb(LD_A, 5); sb(IDL, 3);
        cyc("run_drop"); run = 1'b1;
        drain(4, "run_drop"); run = 1'b0;
        drain(3, "run_drop");
        chk("run_drop_pc", 12'(pc), 12'h002);
        chk("run_drop_acc", 12'(acc), 12'h032);
        run = 1'b1;
        drain(1, "run_drop"); run = 1'b0;
        drain(2, "run_drop");
        chk("run_drop_acc2", 12'(acc), 12'h010);

        chk("sb_drained", 12'(sbq.size()), 12'h000);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
